bcd_serial_adder: RTL and testbench

Digit-serial multi-digit BCD adder: accepts two packed BCD operands plus carry-in on a start pulse and adds them one decimal digit per clock, least-significant digit first. It uses a single-digit BCD adder stage, carrying between digits in a register, and produces a packed BCD sum with carry-out and a done pulse. This is the sequencing stage directly upstream of the 4-bit decimal adder. It extends the one-digit datapath to DIGITS decimal digits without replicating the adder.

---
 rtl/bcd_serial_adder_pkg.sv | 13 +
 rtl/bcd_digit_adder.sv | 26 ++
 rtl/bcd_serial_adder.sv | 126 ++++++++++++
 tb/tb_bcd_serial_adder.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_serial_adder_pkg.sv
// Shared definitions for the digit-serial BCD adder: FSM encoding and BCD constants.
package bcd_serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [4:0] BCD_MAX  = 5'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder with decimal correction of sums above nine.
module bcd_digit_adder
    import bcd_serial_adder_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic       co_o
);

    logic [4:0] t;

    always_comb begin
        t = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, ci_i};
        if (t > BCD_MAX) begin
            // Invalid input digits take the same path; the result wraps modulo 16.
            s_o  = t[3:0] + BCD_CORR;
            co_o = 1'b1;
        end else begin
            s_o  = t[3:0];
            co_o = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per clock, LSD first, sharing one digit adder.
module bcd_serial_adder
    import bcd_serial_adder_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [4*DIGITS-1:0]   a_i,
    input  logic [4*DIGITS-1:0]   b_i,
    input  logic                  ci_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   sum_o,
    output logic                  co_o,
    output logic                  err_o
);

    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            co_q, co_d;
    logic            err_q, err_d;

    logic [3:0] dig_a, dig_b, dig_s;
    logic       dig_co;
    logic       start_err;

    assign dig_a = a_q[4*idx_q +: 4];
    assign dig_b = b_q[4*idx_q +: 4];

    bcd_digit_adder u_digit (
        .a_i  (dig_a),
        .b_i  (dig_b),
        .ci_i (carry_q),
        .s_o  (dig_s),
        .co_o (dig_co)
    );

    always_comb begin
        start_err = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (({1'b0, a_i[4*i +: 4]} > BCD_MAX) || ({1'b0, b_i[4*i +: 4]} > BCD_MAX)) begin
                start_err = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        co_d    = co_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone) begin
                    state_d = StIdle;
                end
                // Accepting in DONE gives back-to-back operations.
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = ci_i;
                    sum_d   = '0;
                    co_d    = 1'b0;
                    err_d   = start_err;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[4*idx_q +: 4] = dig_s;
                carry_d             = dig_co;
                if (idx_q == LastIdx) begin
                    co_d    = dig_co;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            err_q   <= err_d;
        end
    end

    assign busy_o = (state_q == StRun);
    assign done_o = (state_q == StDone);
    assign sum_o  = sum_q;
    assign co_o   = co_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomized self-checking bench for bcd_serial_adder against a decimal/digit-rule model.
module tb_bcd_serial_adder;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         busy, done, co, err;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .ci_i    (ci),
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
        .co_o    (co),
        .err_o   (err)
    );

    // Per-digit rule model, used where operands may hold invalid digits.
    function automatic void ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                    output logic [W-1:0] s, output logic cout, output logic e);
        int carry, da, db, t;
        carry = int'(c);
        s = '0;
        e = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            da = int'(x[4*i +: 4]);
            db = int'(y[4*i +: 4]);
            t  = da + db + carry;
            if (da > 9 || db > 9) e = 1'b1;
            if (t > 9) begin
                s[4*i +: 4] = 4'((t + 6) % 16);
                carry = 1;
            end else begin
                s[4*i +: 4] = 4'(t);
                carry = 0;
            end
        end
        cout = (carry != 0);
    endfunction

    function automatic int bcd2int(input logic [W-1:0] x);
        int v = 0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd(input bit valid_only);
        logic [W-1:0] r = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = valid_only ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
        end
        return r;
    endfunction

    // Returns just after the edge that samples start.
    task automatic pulse_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                               input bit at_negedge);
        if (at_negedge) @(negedge clk);
        a = x;
        b = y;
        ci = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done; busy must be high before done and low with it.
    task automatic wait_done(output int cycles, output bit busy_ok);
        busy_ok = (busy === 1'b1) && (done === 1'b0);
        cycles = 0;
        for (int k = 0; k < 3 * int'(DIGITS) + 4; k++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done === 1'b1) begin
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, co, err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: busy/done/co/err=%b expected 0000", {busy, done, co, err});
        end
        checks++;
        if (sum !== '0) begin
            errors++;
            $display("FAIL reset_sum: got %h expected 0000", sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [W-1:0] va[3] = '{16'h1234, 16'h9999, 16'h0000};
        logic [W-1:0] vb[3] = '{16'h4321, 16'h0001, 16'h9999};
        logic         vc[3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] vs[3] = '{16'h5555, 16'h0000, 16'h0000};
        logic         vo[3] = '{1'b0, 1'b1, 1'b1};
        int cyc;
        bit bok;
        for (int i = 0; i < 3; i++) begin
            pulse_start(va[i], vb[i], vc[i], 1'b1);
            wait_done(cyc, bok);
            checks++;
            if (cyc != int'(DIGITS) || !bok) begin
                errors++;
                $display("FAIL directed_timing[%0d]: done after %0d edges busy_ok=%0d, expected %0d/1",
                         i, cyc, bok, DIGITS);
            end
            checks++;
            if ({sum, co, err} !== {vs[i], vo[i], 1'b0}) begin
                errors++;
                $display("FAIL directed_result[%0d]: sum=%h co=%b err=%b expected sum=%h co=%b err=0",
                         i, sum, co, err, vs[i], vo[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL directed_done_pulse[%0d]: done=%b one cycle later, expected 0", i, done);
            end
        end
    endtask

    task automatic test_sweep;
        int cyc, s;
        bit bok;
        logic [W-1:0] exp_sum;
        for (int x = 0; x < 10; x++) begin
            for (int y = 0; y < 10; y++) begin
                for (int c = 0; c < 2; c++) begin
                    pulse_start(W'(x), W'(y), c[0], 1'b1);
                    wait_done(cyc, bok);
                    s = x + y + c;
                    exp_sum = int2bcd(s);
                    checks++;
                    if (cyc != int'(DIGITS) || {sum, co, err} !== {exp_sum, 2'b00}) begin
                        errors++;
                        $display("FAIL sweep %0d+%0d+%0d: sum=%h co=%b err=%b edges=%0d expected %h/0/0/%0d",
                                 x, y, c, sum, co, err, cyc, exp_sum, DIGITS);
                    end
                end
            end
        end
    endtask

    task automatic test_random;
        int cyc, s;
        bit bok;
        logic [W-1:0] x, y, es;
        logic c, eco, eerr;
        for (int n = 0; n < 40; n++) begin
            x = rand_bcd(1'b1);
            y = rand_bcd(1'b1);
            c = 1'($urandom_range(0, 1));
            pulse_start(x, y, c, 1'b1);
            wait_done(cyc, bok);
            s = bcd2int(x) + bcd2int(y) + int'(c);
            es = int2bcd(s);
            eco = (s >= 10 ** DIGITS);
            checks++;
            if (!bok || cyc != int'(DIGITS) || {sum, co, err} !== {es, eco, 1'b0}) begin
                errors++;
                $display("FAIL random_valid %h+%h+%b: sum=%h co=%b err=%b expected %h/%b/0",
                         x, y, c, sum, co, err, es, eco);
            end
        end
        for (int n = 0; n < 20; n++) begin
            x = rand_bcd(1'b0);
            y = rand_bcd(1'b0);
            c = 1'($urandom_range(0, 1));
            pulse_start(x, y, c, 1'b1);
            wait_done(cyc, bok);
            ref_add(x, y, c, es, eco, eerr);
            checks++;
            if (cyc != int'(DIGITS) || {sum, co, err} !== {es, eco, eerr}) begin
                errors++;
                $display("FAIL random_any %h+%h+%b: sum=%h co=%b err=%b expected %h/%b/%b",
                         x, y, c, sum, co, err, es, eco, eerr);
            end
        end
    endtask

    task automatic test_start_in_run;
        int cyc;
        bit bok;
        pulse_start(16'h1234, 16'h4321, 1'b0, 1'b1);
        // Second request lands in RUN and must not disturb the operation.
        pulse_start(16'h9999, 16'h9999, 1'b1, 1'b1);
        wait_done(cyc, bok);
        checks++;
        if (cyc != int'(DIGITS) - 1 || !bok || {sum, co, err} !== {16'h5555, 2'b00}) begin
            errors++;
            $display("FAIL start_in_run: sum=%h co=%b err=%b edges=%0d expected 5555/0/0/%0d",
                     sum, co, err, cyc, DIGITS - 1);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        bit bok;
        pulse_start(16'h0123, 16'h0456, 1'b0, 1'b1);
        wait_done(cyc, bok);
        checks++;
        if (cyc != int'(DIGITS) || {sum, co} !== {16'h0579, 1'b0}) begin
            errors++;
            $display("FAIL b2b_first: sum=%h co=%b edges=%0d expected 0579/0/%0d", sum, co, cyc, DIGITS);
        end
        // Request sampled on the edge that leaves DONE.
        pulse_start(16'h5000, 16'h5000, 1'b1, 1'b0);
        checks++;
        if ({done, busy} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_handoff: done/busy=%b expected 01", {done, busy});
        end
        wait_done(cyc, bok);
        checks++;
        if (cyc != int'(DIGITS) || !bok || {sum, co, err} !== {16'h0001, 2'b10}) begin
            errors++;
            $display("FAIL b2b_second: sum=%h co=%b err=%b edges=%0d expected 0001/1/0/%0d",
                     sum, co, err, cyc, DIGITS);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_single_pulse: done/busy=%b expected 00", {done, busy});
        end
    endtask

    task automatic test_err;
        int cyc;
        bit bok;
        pulse_start(16'h000A, 16'h0000, 1'b0, 1'b1);
        wait_done(cyc, bok);
        checks++;
        if (cyc != int'(DIGITS) || {sum, co, err} !== {16'h0010, 2'b01}) begin
            errors++;
            $display("FAIL err_set: sum=%h co=%b err=%b expected 0010/0/1", sum, co, err);
        end
        pulse_start(16'h0001, 16'h0002, 1'b0, 1'b1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b expected 0 after valid start", err);
        end
        wait_done(cyc, bok);
        checks++;
        if ({sum, co, err} !== {16'h0003, 2'b00}) begin
            errors++;
            $display("FAIL err_next_op: sum=%h co=%b err=%b expected 0003/0/0", sum, co, err);
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        bit bok;
        pulse_start(16'h1239, 16'h4329, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, co, err} !== 4'b0000 || sum !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: busy/done/co/err=%b sum=%h expected 0000/0000",
                     {busy, done, co, err}, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start(16'h0999, 16'h0001, 1'b0, 1'b1);
        wait_done(cyc, bok);
        checks++;
        if (cyc != int'(DIGITS) || !bok || {sum, co, err} !== {16'h1000, 2'b00}) begin
            errors++;
            $display("FAIL after_reset_op: sum=%h co=%b err=%b edges=%0d expected 1000/0/0/%0d",
                     sum, co, err, cyc, DIGITS);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sweep();
        test_random();
        test_start_in_run();
        test_back_to_back();
        test_err();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
